// File: rtl/param_mcycle_cpu.sv
// param_mcycle_cpu: multi-cycle 4-opcode core with an instruction-fetch handshake,
// a valid/ready output port, sticky signed overflow, halt detection and debug register reads.
module param_mcycle_cpu #(
  parameter int DATA_W = 8,
  parameter int RA_W = 2,
  parameter int PC_W = 8,
  localparam int INST_W = 2 + 3 * RA_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   pc,
  output logic              ovf,
  output logic              halted,
  input  logic [RA_W-1:0]   dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {FETCH, EXEC, OUTW, HALT} state_e;
  localparam int NREG = 1 << RA_W;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic ovf_q, ovf_d;
  logic halted_q, halted_d;
  logic we;
  logic [1:0] op;
  logic [RA_W-1:0] rs, rt, rd, wa;
  logic [DATA_W-1:0] a, b, sum;
  logic [PC_W-1:0] joff;
  logic sovf;
  assign op = ir_q[INST_W-1 -: 2];
  assign rs = ir_q[3*RA_W-1 -: RA_W];
  assign rt = ir_q[2*RA_W-1 -: RA_W];
  assign rd = ir_q[RA_W-1:0];
  assign joff = PC_W'($signed(ir_q[3*RA_W-1:0]));
  // ADD uses rt as second operand and rd as destination; ADDI uses the rd field as imm and writes rt
  assign a = regs_q[rs];
  assign b = op == 2'b00 ? regs_q[rt] : DATA_W'($signed(rd));
  assign sum = a + b;
  assign sovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign wa = op == 2'b00 ? rd : rt;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d = ovf_q;
    halted_d = halted_q;
    we = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          ir_d = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!op[1]) begin
          we = 1'b1;
          ovf_d = ovf_q | sovf;
          pc_d = pc_q + PC_W'(1);
          state_d = FETCH;
        end else if (!op[0]) begin
          out_data_d = a;
          out_valid_d = 1'b1;
          state_d = OUTW;
        end else if (joff != '0) begin
          pc_d = pc_q + joff;
          state_d = FETCH;
        end else begin
          halted_d = 1'b1;
          state_d = HALT;
        end
      end
      OUTW: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d = pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q <= ovf_d;
      halted_q <= halted_d;
      if (we) regs_q[wa] <= sum;
    end
  end
  assign imem_req = state_q == FETCH;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign ovf = ovf_q;
  assign halted = halted_q;
  assign dbg_data = regs_q[dbg_sel];
endmodule

// File: tb/tb_param_mcycle_cpu.sv
// tb_param_mcycle_cpu: directed plus randomized program run against an instruction-level model.
module tb_param_mcycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic imem_req;
  logic [7:0] imem_addr;
  logic imem_valid = 1'b0;
  logic [7:0] imem_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic [7:0] pc;
  logic ovf;
  logic halted;
  logic [1:0] dbg_sel = '0;
  logic [7:0] dbg_data;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic m_ovf;
  logic m_halt;

  param_mcycle_cpu dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pc(pc), .ovf(ovf), .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_pc = '0;
    m_ovf = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk(tag, dbg_data, m_r[i]);
    end
  endtask

  // drives one instruction through FETCH with wn wait states; returns at the negedge inside EXEC
  task automatic fetch(input logic [7:0] inst, input int wn);
    for (int i = 0; i < wn; i++) begin
      imem_valid = 1'b0;
      imem_data = 8'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      chk("wait_pc", pc, m_pc);
    end
    imem_valid = 1'b1;
    imem_data = inst;
    out_ready = 1'($urandom);
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data = 8'($urandom);
    chk("exec_req", imem_req, 0);
    chk("exec_pc", pc, m_pc);
  endtask

  task automatic finish(input logic [7:0] inst, input int rdly);
    int op = int'(inst[7:6]);
    int rs = int'(inst[5:4]);
    int rt = int'(inst[3:2]);
    int rd = int'(inst[1:0]);
    int a, b, s, j;
    @(negedge clk);
    if (op < 2) begin
      a = $signed(m_r[rs]);
      b = op == 0 ? $signed(m_r[rt]) : (rd >= 2 ? rd - 4 : rd);
      s = a + b;
      if (s > 127 || s < -128) m_ovf = 1'b1;
      m_r[op == 0 ? rd : rt] = 8'(s);
      m_pc = m_pc + 8'd1;
    end else if (op == 2) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, m_r[rs]);
      for (int i = 0; i < rdly; i++) begin
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, m_r[rs]);
        chk("bp_pc", pc, m_pc);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      m_pc = m_pc + 8'd1;
    end else begin
      j = int'(inst[5:0]);
      if (j >= 32) j -= 64;
      if (j == 0) m_halt = 1'b1;
      else m_pc = 8'(int'(m_pc) + j);
    end
    chk("pc", pc, m_pc);
    chk("ovf", ovf, m_ovf);
    chk("halted", halted, m_halt);
    chk("req", imem_req, !m_halt);
    chk("addr", imem_addr, m_pc);
    chk("out_idle", out_valid, 0);
    check_regs("regs");
  endtask

  task automatic run(input logic [7:0] inst, input int wn, input int rdly);
    fetch(inst, wn);
    finish(inst, rdly);
  endtask

  initial begin
    logic [7:0] inst;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 0);
    chk("rel_pc", pc, 0);
    chk("rel_ovf", ovf, 0);
    chk("rel_valid", out_valid, 0);
    check_regs("rel_regs");
    run(8'h45, 0, 0);
    run(8'h16, 0, 0);
    chk("arith_r2", m_r[2], 8'd2);
    for (int i = 0; i < 7; i++) run(8'h15, 0, 0);
    chk("ovf_r1", m_r[1], 8'h80);
    chk("ovf_set", ovf, 1);
    run(8'h41, 0, 0);
    run(8'hA0, 0, 5);
    inst = {2'b11, 6'(8'd5 - m_pc)};
    run(inst, 1, 0);
    run(8'hFF, 0, 0);
    chk("jmp_back", pc, 8'd4);
    for (int n = 0; n < 40; n++) begin
      inst = 8'($urandom);
      if (inst == 8'hC0) inst = 8'hC1;
      run(inst, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run(8'hC0, 2, 0);
    for (int i = 0; i < 20; i++) begin
      imem_valid = 1'($urandom);
      imem_data = 8'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_pc", pc, m_pc);
    end
    imem_valid = 1'b0;
    check_regs("halt_regs");
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst2_halted", halted, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(8'h4D, 0, 0);
    fetch(8'hB0, 3);
    out_ready = 1'b0;
    @(negedge clk);
    chk("outw_valid", out_valid, 1);
    chk("outw_data", out_data, 8'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_valid", out_valid, 0);
    chk("async_data", out_data, 0);
    chk("async_pc", pc, 0);
    dbg_sel = 2'd3;
    #1;
    chk("async_r3", dbg_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel2_req", imem_req, 1);
    chk("rel2_addr", imem_addr, 0);
    run(8'h45, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
